// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: state encoding, fault cause codes, reset instruction.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    FAULT = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection for the fetch stage: jalr > branch/jal > sequential, plus the alignment check.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            Jalr,
  output logic [XLEN-1:0] PCNext,
  output logic            Misaligned
);

  always_comb begin
    PCNext = PC + 32'd4;
    if (Jalr) begin
      PCNext = ALUResult & ~32'h0000_0001;
    end else if (Branch || Jump) begin
      PCNext = PC + ImmExt;
    end
    // Targets must be word aligned; jalr only clears bit 0, so bit 1 can still fault.
    Misaligned = |PCNext[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register and instruction-fetch FSM (FETCH/EXEC/FAULT) with sticky misalignment fault.
// Optional fetch-wait timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Jalr,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic        Stall,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        Fault,
  output logic [1:0]  FaultCause,
  output logic [31:0] FaultPC
);

  state_t            state, state_next;
  logic [XLEN-1:0]   pc_q, pc_next;
  logic [XLEN-1:0]   instr_q, instr_next;
  logic [1:0]        cause_q, cause_next;
  logic [XLEN-1:0]   fault_pc_q, fault_pc_next;
  logic [XLEN-1:0]   target;
  logic              misaligned;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_count, wait_count_next;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  next_pc_sel u_next_pc_sel (
    .PC         (pc_q),
    .ImmExt     (ImmExt),
    .ALUResult  (ALUResult),
    .Branch     (Branch),
    .Jump       (Jump),
    .Jalr       (Jalr),
    .PCNext     (target),
    .Misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      cause_q    <= CAUSE_NONE;
      fault_pc_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_count <= '0;
`endif
    end else begin
      state      <= state_next;
      pc_q       <= pc_next;
      instr_q    <= instr_next;
      cause_q    <= cause_next;
      fault_pc_q <= fault_pc_next;
`ifdef FETCH_TIMEOUT_EN
      wait_count <= wait_count_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc_q;
    instr_next    = instr_q;
    cause_next    = cause_q;
    fault_pc_next = fault_pc_q;
`ifdef FETCH_TIMEOUT_EN
    wait_count_next = wait_count;
`endif
    case (state)
      FETCH: begin
        // An ack in the limit cycle still wins over the timeout.
        if (ImemAck) begin
          instr_next = ImemRdata;
          state_next = EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_count == LIMIT) begin
          state_next    = FAULT;
          cause_next    = CAUSE_TIMEOUT;
          fault_pc_next = pc_q;
        end else begin
          wait_count_next = wait_count + 1'b1;
        end
`endif
      end
      EXEC: begin
        if (!Stall) begin
          if (misaligned) begin
            state_next    = FAULT;
            cause_next    = CAUSE_MISALIGN;
            fault_pc_next = target;
          end else begin
            pc_next    = target;
            state_next = FETCH;
`ifdef FETCH_TIMEOUT_EN
            wait_count_next = '0;
`endif
          end
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // The request drops combinationally while reset is held so memory never sees a fetch during reset.
  assign ImemReq    = (state == FETCH) && !reset;
  assign ImemAddr   = pc_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc_q + 32'd4;
  assign Instr      = instr_q;
  assign InstrValid = (state == EXEC);
  assign Fault      = (state == FAULT);
  assign FaultCause = cause_q;
  assign FaultPC    = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; expected fetch addresses flow through a scoreboard queue.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam int          TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        Branch, Jump, Jalr, Stall, ImemAck;
  logic [31:0] ImmExt, ALUResult, ImemRdata;
  logic        ImemReq, InstrValid, Fault;
  logic [31:0] ImemAddr, PC, PCPlus4, Instr, FaultPC;
  logic [1:0]  FaultCause;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];
  logic [31:0] pc_model;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .Branch     (Branch),
    .Jump       (Jump),
    .Jalr       (Jalr),
    .ImmExt     (ImmExt),
    .ALUResult  (ALUResult),
    .Stall      (Stall),
    .ImemAck    (ImemAck),
    .ImemRdata  (ImemRdata),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .Fault      (Fault),
    .FaultCause (FaultCause),
    .FaultPC    (FaultPC)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Waits waitCycles with ack withheld, then acks; pops the expected address from the scoreboard.
  task automatic fetchInstr(input logic [31:0] data, input int waitCycles);
    logic [31:0] exp_addr;
    for (int i = 0; i < waitCycles; i++) begin
      checkOutput("req_held", {31'b0, ImemReq}, 32'd1);
      checkOutput("addr_held", ImemAddr, pc_model);
      @(negedge clk);
    end
    checkOutput("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
    exp_addr = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    checkOutput("req", {31'b0, ImemReq}, 32'd1);
    checkOutput("imem_addr", ImemAddr, exp_addr);
    ImemAck   = 1'b1;
    ImemRdata = data;
    @(negedge clk);
    ImemAck   = 1'b0;
    checkOutput("instr_valid", {31'b0, InstrValid}, 32'd1);
    checkOutput("instr", Instr, data);
    checkOutput("req_exec", {31'b0, ImemReq}, 32'd0);
  endtask

  // Drives one non-stalled execute cycle and records where the next fetch must go.
  task automatic applyStimulus(input logic br, input logic jmp, input logic jr,
                               input logic [31:0] imm, input logic [31:0] alu,
                               input logic [31:0] exp_next);
    checkOutput("pc", PC, pc_model);
    checkOutput("pc_plus4", PCPlus4, pc_model + 32'd4);
    Branch = br; Jump = jmp; Jalr = jr; ImmExt = imm; ALUResult = alu;
    sb.push_back(exp_next);
    pc_model = exp_next;
    @(negedge clk);
    Branch = 1'b0; Jump = 1'b0; Jalr = 1'b0; ImmExt = '0; ALUResult = '0;
    checkOutput("pc_next", PC, exp_next);
  endtask

  initial begin
    reset = 1'b1; Branch = 1'b0; Jump = 1'b0; Jalr = 1'b0; Stall = 1'b0;
    ImemAck = 1'b0; ImmExt = '0; ALUResult = '0; ImemRdata = '0;
    pc_model = RST_PC;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req", {31'b0, ImemReq}, 32'd0);
    checkOutput("rst_pc", PC, RST_PC);
    checkOutput("rst_instr", Instr, 32'h0000_0013);
    checkOutput("rst_valid", {31'b0, InstrValid}, 32'd0);
    checkOutput("rst_fault", {31'b0, Fault}, 32'd0);
    checkOutput("rst_cause", {30'b0, FaultCause}, 32'd0);
    checkOutput("rst_fpc", FaultPC, 32'd0);

    reset = 1'b0;
    sb.push_back(RST_PC);
    #1;
    fetchInstr(32'h0000_0013, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0004);
    fetchInstr(32'h00C0_006F, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'h0000_0010);
    fetchInstr(32'hFE00_0CE3, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0000_0008);
    fetchInstr(32'h0180_006F, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0018, 32'h0, 32'h0000_0020);
    fetchInstr(32'h1000_006F, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0120);
    fetchInstr(32'h0410_0067, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0041, 32'h0000_0040);

    fetchInstr(32'h0000_0033, 2);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_valid", {31'b0, InstrValid}, 32'd1);
      checkOutput("stall_pc", PC, 32'h0000_0040);
      @(negedge clk);
    end
    Stall = 1'b0;
    checkOutput("stall_instr", Instr, 32'h0000_0033);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0044);

    for (int i = 0; i < 2; i++) begin
      checkOutput("wait_req", {31'b0, ImemReq}, 32'd1);
      checkOutput("wait_addr", ImemAddr, 32'h0000_0044);
      @(negedge clk);
    end
    reset = 1'b1; ImemAck = 1'b1; ImemRdata = 32'hBAD0_BAD0;
    #1;
    checkOutput("req_in_reset", {31'b0, ImemReq}, 32'd0);
    @(negedge clk);
    reset = 1'b0; ImemAck = 1'b0;
    sb.delete();
    pc_model = RST_PC;
    sb.push_back(RST_PC);
    #1;
    checkOutput("midwait_rst_pc", PC, RST_PC);
    checkOutput("midwait_rst_valid", {31'b0, InstrValid}, 32'd0);
    checkOutput("midwait_rst_instr", Instr, 32'h0000_0013);
    fetchInstr(32'h2030_8067, 2);

    Jalr = 1'b1; ALUResult = 32'h0000_0203;
    @(negedge clk);
    Jalr = 1'b0; ALUResult = '0;
    checkOutput("mis_fault", {31'b0, Fault}, 32'd1);
    checkOutput("mis_cause", {30'b0, FaultCause}, 32'd1);
    checkOutput("mis_fpc", FaultPC, 32'h0000_0202);
    checkOutput("mis_pc", PC, RST_PC);
    checkOutput("mis_valid", {31'b0, InstrValid}, 32'd0);
    ImemAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("fault_req", {31'b0, ImemReq}, 32'd0);
      checkOutput("fault_sticky", {31'b0, Fault}, 32'd1);
      @(negedge clk);
    end
    ImemAck = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("clr_fault", {31'b0, Fault}, 32'd0);
    checkOutput("clr_cause", {30'b0, FaultCause}, 32'd0);
    checkOutput("clr_req", {31'b0, ImemReq}, 32'd1);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT; i++) begin
      checkOutput("to_nofault", {31'b0, Fault}, 32'd0);
      @(negedge clk);
    end
    checkOutput("to_fault", {31'b0, Fault}, 32'd1);
    checkOutput("to_cause", {30'b0, FaultCause}, 32'd2);
    checkOutput("to_fpc", FaultPC, RST_PC);
    checkOutput("to_req", {31'b0, ImemReq}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) @(negedge clk);
    ImemAck = 1'b1; ImemRdata = 32'h0000_0013;
    @(negedge clk);
    ImemAck = 1'b0;
    checkOutput("limit_ack_valid", {31'b0, InstrValid}, 32'd1);
    checkOutput("limit_ack_nofault", {31'b0, Fault}, 32'd0);
`else
    for (int i = 0; i < 20; i++) @(negedge clk);
    checkOutput("long_wait_nofault", {31'b0, Fault}, 32'd0);
    checkOutput("long_wait_req", {31'b0, ImemReq}, 32'd1);
    checkOutput("long_wait_cause", {30'b0, FaultCause}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
